// File: rtl/hb3_multi_ctrl_if.sv
// Signal bundle between the AXI register file / Pmod pins and the multi-channel HB3 controller.
interface hb3_multi_ctrl_if #(
  parameter int NUM_CH   = 2,
  parameter int PWM_BITS = 8,
  parameter int CNT_BITS = 16
);
  logic [NUM_CH*PWM_BITS-1:0] reg_duty;
  logic [2*NUM_CH-1:0]        reg_control;
  logic [NUM_CH-1:0]          pinA;
  logic [NUM_CH-1:0]          pwm;
  logic [NUM_CH-1:0]          dir_out;
  logic [NUM_CH*CNT_BITS-1:0] reg_count;
  logic                       count_valid;
  logic [NUM_CH-1:0]          busy;

  modport master (
    output reg_duty, reg_control, pinA,
    input  pwm, dir_out, reg_count, count_valid, busy
  );

  modport slave (
    input  reg_duty, reg_control, pinA,
    output pwm, dir_out, reg_count, count_valid, busy
  );
endinterface

// File: rtl/hb3_multi_ctrl.sv
// Multi-channel H-bridge driver: shared PWM timebase, per-channel dead-time interlock FSM,
// and per-channel encoder edge counting over a shared gate window.
module hb3_multi_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int PWM_BITS     = 8,
  parameter int PWM_PRESCALE = 16,
  parameter int DEAD_CYCLES  = 1000,
  parameter int GATE_CYCLES  = 100_000_000,
  parameter int CNT_BITS     = 16
) (
  input  logic            clk,
  input  logic            resetN,
  hb3_multi_ctrl_if.slave bus
);
  localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_PRESCALE - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COAST = 2'd2} state_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic e);
    if (e && (v != {CNT_BITS{1'b1}})) return v + CNT_BITS'(1);
    return v;
  endfunction

  logic [PRE_W-1:0]           r_pre;
  logic [PWM_BITS-1:0]        r_cnt;
  logic                       r_boot;
  logic [PWM_BITS-1:0]        r_duty [NUM_CH];
  state_t                     r_state [NUM_CH];
  state_t                     w_next [NUM_CH];
  logic [DEAD_W-1:0]          r_dead [NUM_CH];
  logic [NUM_CH-1:0]          r_dir;
  logic [NUM_CH-1:0]          r_pwm;
  logic [NUM_CH-1:0]          r_busy;
  logic [NUM_CH-1:0]          r_sync1;
  logic [NUM_CH-1:0]          r_sync2;
  logic [NUM_CH-1:0]          r_prev;
  logic [GATE_W-1:0]          r_gate;
  logic [CNT_BITS-1:0]        r_acc [NUM_CH];
  logic [NUM_CH*CNT_BITS-1:0] r_count;
  logic                       r_cv;

  logic [NUM_CH-1:0]          w_en;
  logic [NUM_CH-1:0]          w_req;
  logic [NUM_CH-1:0]          w_dead_last;
  logic [NUM_CH-1:0]          w_edge;
  logic                       w_pre_wrap;
  logic                       w_load_duty;
  logic                       w_gate_last;

  assign w_pre_wrap  = (r_pre == PRE_LAST);
  assign w_load_duty = r_boot || (w_pre_wrap && (r_cnt == {PWM_BITS{1'b1}}));
  assign w_gate_last = (r_gate == GATE_LAST);
  assign w_edge      = r_sync2 & ~r_prev;

  // Shared PWM timebase; duty latches reload only at period start or right after reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_boot <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else begin
      r_boot <= 1'b0;
      r_pre  <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
      if (w_pre_wrap) r_cnt <= r_cnt + PWM_BITS'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_load_duty) r_duty[i] <= bus.reg_duty[i*PWM_BITS +: PWM_BITS];
      end
    end
  end

  // Per-channel FSM next state
  always_comb begin
    w_en        = '0;
    w_req       = '0;
    w_dead_last = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_en[i]        = bus.reg_control[2*i];
      w_req[i]       = bus.reg_control[2*i+1];
      w_dead_last[i] = (r_dead[i] == DEAD_LAST);
      w_next[i]      = r_state[i];
      case (r_state[i])
        IDLE: begin
          if (w_req[i] != r_dir[i]) w_next[i] = COAST;
          else if (w_en[i])         w_next[i] = RUN;
        end
        RUN: begin
          if (w_req[i] != r_dir[i]) w_next[i] = COAST;
          else if (!w_en[i])        w_next[i] = IDLE;
        end
        COAST: begin
          if (w_dead_last[i]) w_next[i] = w_en[i] ? RUN : IDLE;
        end
        default: w_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_next[i];
    end
  end

  // Dead-time counter, direction register and registered drive outputs.
  // A pending direction request already blanks pwm so the bridge is never driven
  // in the cycle it starts to coast.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_dir  <= '0;
      r_pwm  <= '0;
      r_busy <= '0;
      for (int i = 0; i < NUM_CH; i++) r_dead[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_dead[i] <= ((r_state[i] == COAST) && !w_dead_last[i]) ? r_dead[i] + DEAD_W'(1) : '0;
        if ((r_state[i] == COAST) && w_dead_last[i]) r_dir[i] <= w_req[i];
        r_pwm[i]  <= (r_state[i] == RUN) && (w_req[i] == r_dir[i]) && (r_cnt < r_duty[i]);
        r_busy[i] <= (w_next[i] == COAST);
      end
    end
  end

  // Encoder sync, edge detect and gated accumulation; the terminal-cycle edge
  // is folded into the latched value so it is neither lost nor carried over.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_gate  <= '0;
      r_cv    <= 1'b0;
      r_count <= '0;
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else begin
      r_sync1 <= bus.pinA;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_gate  <= w_gate_last ? '0 : r_gate + GATE_W'(1);
      r_cv    <= w_gate_last;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_gate_last) begin
          r_count[i*CNT_BITS +: CNT_BITS] <= sat_inc(r_acc[i], w_edge[i]);
          r_acc[i] <= '0;
        end else begin
          r_acc[i] <= sat_inc(r_acc[i], w_edge[i]);
        end
      end
    end
  end

  assign bus.pwm         = r_pwm;
  assign bus.dir_out     = r_dir;
  assign bus.busy        = r_busy;
  assign bus.reg_count   = r_count;
  assign bus.count_valid = r_cv;

endmodule

// File: tb/tb_hb3_multi_ctrl.sv
// Self-checking bench for hb3_multi_ctrl: PWM duty, dead-time interlock, encoder windows, reset.
module tb_hb3_multi_ctrl;
  localparam int NUM_CH       = 2;
  localparam int PWM_BITS     = 4;
  localparam int PWM_PRESCALE = 2;
  localparam int DEAD_CYCLES  = 10;
  localparam int GATE_CYCLES  = 200;
  localparam int CNT_BITS     = 4;
  localparam int PERIOD       = (1 << PWM_BITS) * PWM_PRESCALE;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  hb3_multi_ctrl_if #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .CNT_BITS(CNT_BITS)) bus ();

  hb3_multi_ctrl #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PWM_PRESCALE(PWM_PRESCALE),
    .DEAD_CYCLES(DEAD_CYCLES), .GATE_CYCLES(GATE_CYCLES), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [2*CNT_BITS-1:0] sb_q [$];
  logic [2*CNT_BITS-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycles since the last reset edge; the DUT timebase and gate counter align to it.
  always @(posedge clk) begin
    if (!resetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.count_valid === 1'b1 || (cyc > 0 && cyc % GATE_CYCLES == 0))
        chk("cv_phase", 32'(bus.count_valid), 32'(cyc > 0 && cyc % GATE_CYCLES == 0));
      if (bus.count_valid === 1'b1) begin
        exp_cnt = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("cnt0", 32'(bus.reg_count[CNT_BITS-1:0]), 32'(exp_cnt[CNT_BITS-1:0]));
        chk("cnt1", 32'(bus.reg_count[2*CNT_BITS-1:CNT_BITS]), 32'(exp_cnt[2*CNT_BITS-1:CNT_BITS]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_hi(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.pwm[ch] === 1'b1) hi++;
    end
  endtask

  task automatic wait_phase(input int modulo, input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % modulo) != ph && n < 4 * modulo);
  endtask

  // Flip ch1's direction request and watch the coast span; optionally flip it back at back_at.
  task automatic coast_watch(input int back_at, output int busy_n, output int pwm_hi, output int chg_at);
    logic d0;
    d0 = bus.dir_out[1];
    busy_n = 0;
    pwm_hi = 0;
    chg_at = -1;
    bus.reg_control[3] = ~bus.reg_control[3];
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == back_at) bus.reg_control[3] = ~bus.reg_control[3];
      if (bus.busy[1] === 1'b1) busy_n++;
      if (j <= DEAD_CYCLES && bus.pwm[1] !== 1'b0) pwm_hi++;
      if (chg_at < 0 && bus.dir_out[1] !== d0) chg_at = j;
    end
  endtask

  initial begin
    int hi, bn, ph, ca, n;
    int duties [3] = '{0, 5, 15};
    bus.reg_duty    = '0;
    bus.reg_control = '0;
    bus.pinA        = '0;
    resetN          = 1'b0;
    tick(3);
    mon_en = 1'b1;
    chk("rst_pwm",   32'(bus.pwm), 32'(0));
    chk("rst_dir",   32'(bus.dir_out), 32'(0));
    chk("rst_busy",  32'(bus.busy), 32'(0));
    chk("rst_count", 32'(bus.reg_count), 32'(0));
    chk("rst_cv",    32'(bus.count_valid), 32'(0));
    resetN = 1'b1;

    // Duty sweep on ch0: D high counts of PWM_PRESCALE clk each per period
    bus.reg_control[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.reg_duty[3:0] = 4'(duties[k]);
      tick(2 * PERIOD + 4);
      count_hi(0, PERIOD, hi);
      chk("duty_sweep", 32'(hi), 32'(duties[k] * PWM_PRESCALE));
    end

    // Mid-period write: old duty 5 holds until the period boundary
    bus.reg_duty[3:0] = 4'd5;
    tick(2 * PERIOD + 4);
    wait_phase(PERIOD, 12);
    bus.reg_duty[3:0] = 4'd15;
    count_hi(0, PERIOD - 12, hi);
    chk("mid_old", 32'(hi), 32'(0));
    count_hi(0, PERIOD, hi);
    chk("mid_new", 32'(hi), 32'(30));

    // Interlock on ch1
    bus.reg_duty[7:4]  = 4'd15;
    bus.reg_control[2] = 1'b1;
    tick(2 * PERIOD + 4);
    count_hi(1, PERIOD, hi);
    chk("ch1_run", 32'(hi), 32'(30));
    coast_watch(-1, bn, ph, ca);
    chk("il_busy",   32'(bn), 32'(DEAD_CYCLES));
    chk("il_pwm_hi", 32'(ph), 32'(0));
    chk("il_dir_at", 32'(ca), 32'(DEAD_CYCLES));
    chk("il_dir",    32'(bus.dir_out[1]), 32'(1));
    tick(PERIOD);
    count_hi(1, PERIOD, hi);
    chk("il_resume", 32'(hi), 32'(30));

    // Request toggled back during COAST: full coast, direction unchanged
    coast_watch(2, bn, ph, ca);
    chk("tb_busy",   32'(bn), 32'(DEAD_CYCLES));
    chk("tb_pwm_hi", 32'(ph), 32'(0));
    chk("tb_dir_at", 32'(ca), 32'(-1));
    chk("tb_dir",    32'(bus.dir_out[1]), 32'(1));
    tick(PERIOD);
    count_hi(1, PERIOD, hi);
    chk("tb_resume", 32'(hi), 32'(30));

    // Encoder: 7 pulses on ch0, 20 on ch1 (saturates at 15) in one window
    wait_phase(GATE_CYCLES, 1);
    sb_q.push_back({4'd15, 4'd7});
    for (int p = 0; p < 20; p++) begin
      bus.pinA = {1'b1, 1'(p < 7)};
      tick(2);
      bus.pinA = '0;
      tick(2);
    end

    // Three pulses plus one edge detected on the terminal cycle of the window
    wait_phase(GATE_CYCLES, 1);
    sb_q.push_back({4'd0, 4'd4});
    for (int p = 0; p < 3; p++) begin
      bus.pinA[0] = 1'b1;
      tick(2);
      bus.pinA[0] = 1'b0;
      tick(2);
    end
    wait_phase(GATE_CYCLES, GATE_CYCLES - 3);
    bus.pinA[0] = 1'b1;
    tick(1);
    bus.pinA[0] = 1'b0;

    // Reset during COAST and mid-window; pending edges must be discarded
    wait_phase(GATE_CYCLES, 1);
    bus.pinA = 2'b11;
    tick(2);
    bus.pinA = '0;
    tick(4);
    bus.reg_control[3] = 1'b0;
    tick(4);
    chk("pre_rst_busy", 32'(bus.busy[1]), 32'(1));
    chk("pre_rst_cnt",  32'(bus.reg_count[3:0]), 32'(4));
    resetN = 1'b0;
    tick(1);
    chk("rst2_pwm",   32'(bus.pwm), 32'(0));
    chk("rst2_dir",   32'(bus.dir_out), 32'(0));
    chk("rst2_busy",  32'(bus.busy), 32'(0));
    chk("rst2_count", 32'(bus.reg_count), 32'(0));
    chk("rst2_cv",    32'(bus.count_valid), 32'(0));
    sb_q.delete();
    tick(2);
    resetN = 1'b1;
    n = 0;
    while (bus.count_valid !== 1'b1 && n < 3 * GATE_CYCLES) begin
      @(negedge clk);
      n++;
    end
    chk("first_cv", 32'(cyc), 32'(GATE_CYCLES));
    tick(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
